// File: rtl/store_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer_if
// Brief    : CPU-side and data-RAM-side signals of the store buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface store_buffer_if;
    logic        cpu_we;
    logic        cpu_re;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        buf_empty;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_datain;
    logic [31:0] mem_dataout;

    // master: CPU datapath plus data RAM (the environment around the buffer)
    modport master (
        output cpu_we, cpu_re, cpu_addr, cpu_wdata, mem_dataout,
        input  cpu_rdata, stall, buf_empty, mem_we, mem_addr, mem_datain
    );

    modport slave (
        input  cpu_we, cpu_re, cpu_addr, cpu_wdata, mem_dataout,
        output cpu_rdata, stall, buf_empty, mem_we, mem_addr, mem_datain
    );
endinterface
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer
// Brief    : Write-posting FIFO between CPU and single-port data RAM, with
//            youngest-match load forwarding; drains only on non-load cycles.
// Revision : 1.0 - initial release
// ============================================================================
module store_buffer #(
    parameter int DEPTH   = 4,
    parameter int ADDR_HI = 6
) (
    input  wire logic       clk,
    input  wire logic       rst,
    store_buffer_if.slave   bus
);
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [31:0]        r_addr [DEPTH];
    logic [31:0]        r_data [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    logic               w_full;
    logic               w_drain;
    logic               w_enq;
    logic [c_PTR_W-1:0] w_idx;
    logic [31:0]        w_rdata;

    assign w_full  = (r_count == c_CNT_W'(DEPTH));
    // A load owns the RAM port; any other cycle with pending stores drains one.
    assign w_drain = ~rst & ~bus.cpu_re & (r_count != '0);
    // A full buffer refuses the store even if a drain frees a slot this edge.
    assign w_enq   = bus.cpu_we & ~w_full;

    assign bus.stall      = ~rst & bus.cpu_we & w_full;
    assign bus.buf_empty  = (r_count == '0);
    assign bus.mem_we     = w_drain;
    assign bus.mem_addr   = w_drain ? r_addr[r_head] : bus.cpu_addr;
    assign bus.mem_datain = w_drain ? r_data[r_head] : bus.cpu_wdata;
    assign bus.cpu_rdata  = w_rdata;

    // Walk oldest to youngest so the last match (youngest store) wins.
    always_comb begin
        w_rdata = bus.mem_dataout;
        w_idx   = r_head;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + c_PTR_W'(i);
            if (r_valid[w_idx] &&
                (r_addr[w_idx][ADDR_HI:2] == bus.cpu_addr[ADDR_HI:2])) begin
                w_rdata = r_data[w_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_drain) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + c_PTR_W'(1);
            end
            if (w_enq) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + c_PTR_W'(1);
            end
            if (w_enq && !w_drain) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (!w_enq && w_drain) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    // Payload storage needs no reset; valid bits qualify every use.
    always_ff @(posedge clk) begin
        if (!rst && w_enq) begin
            r_addr[r_tail] <= bus.cpu_addr;
            r_data[r_tail] <= bus.cpu_wdata;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_buffer
// Brief    : Directed and random stimulus against a queue-based memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_buffer;
    localparam int c_DEPTH   = 4;
    localparam int c_ADDR_HI = 6;
    localparam int c_WORDS   = 32;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        preload;
    logic [31:0] ram     [c_WORDS];
    logic [31:0] exp_ram [c_WORDS];
    ent_t        q[$];
    int          pass_cnt;
    int          total_cnt;

    store_buffer_if bus();

    store_buffer #(
        .DEPTH   (c_DEPTH),
        .ADDR_HI (c_ADDR_HI)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 20) return 32'h0000_00a3;
        return 32'hA500_0000 ^ (32'(i) * 32'h0101_0101);
    endfunction

    // Data RAM: combinational read, write committed on the clock edge.
    assign bus.mem_dataout = ram[bus.mem_addr[c_ADDR_HI:2]];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < c_WORDS; i++) ram[i] <= init_word(i);
        end else if (bus.mem_we) begin
            ram[bus.mem_addr[c_ADDR_HI:2]] <= bus.mem_datain;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One CPU cycle: drive, check mid-cycle, then advance the model at the edge.
    task automatic cyc(input logic we, input logic re, input logic rs,
                       input logic [31:0] a, input logic [31:0] d);
        logic [31:0] exp_rd;
        logic        e_stall;
        logic        e_drain;
        bus.cpu_we    = we;
        bus.cpu_re    = re;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        rst           = rs;
        @(negedge clk);
        e_stall = !rs && we && (q.size() == c_DEPTH);
        e_drain = !rs && !re && (q.size() > 0);
        exp_rd  = exp_ram[a[c_ADDR_HI:2]];
        foreach (q[i]) if (q[i].addr[c_ADDR_HI:2] == a[c_ADDR_HI:2]) exp_rd = q[i].data;
        check("stall", 32'(bus.stall), 32'(e_stall));
        check("mem_we", 32'(bus.mem_we), 32'(e_drain));
        check("buf_empty", 32'(bus.buf_empty), 32'(q.size() == 0));
        if (re && !rs) begin
            check("cpu_rdata", bus.cpu_rdata, exp_rd);
            check("load_addr", bus.mem_addr, a);
        end
        if (e_drain) begin
            check("drain_addr", bus.mem_addr, q[0].addr);
            check("drain_data", bus.mem_datain, q[0].data);
        end
        @(posedge clk);
        if (rs) begin
            q.delete();
        end else begin
            if (e_drain) begin
                exp_ram[q[0].addr[c_ADDR_HI:2]] = q[0].data;
                void'(q.pop_front());
            end
            if (we && !e_stall) q.push_back('{addr: a, data: d});
        end
        #1;
    endtask

    task automatic drain_all();
        for (int i = 0; i < 2 * c_DEPTH + 2; i++) begin
            if (q.size() > 0) cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        pass_cnt      = 0;
        total_cnt     = 0;
        preload       = 1'b1;
        rst           = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.cpu_re    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        for (int i = 0; i < c_WORDS; i++) exp_ram[i] = init_word(i);
        @(posedge clk);
        #1;
        preload = 1'b0;

        // Reset, idle, passthrough load
        cyc(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h50, 32'h0);

        // Single store then idle drain
        cyc(1'b1, 1'b0, 1'b0, 32'h60, 32'h258);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("ram_0x18", ram[24], 32'h258);

        // Youngest-match forwarding
        cyc(1'b1, 1'b0, 1'b0, 32'h60, 32'h111);
        cyc(1'b1, 1'b0, 1'b0, 32'h60, 32'h222);
        cyc(1'b0, 1'b1, 1'b0, 32'h60, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h64, 32'h0);
        drain_all();

        // Fill with loads blocking the drain, stall, then retry
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 32'h10 + 32'(4 * i), 32'hB0 + 32'(i));
        cyc(1'b1, 1'b0, 1'b0, 32'h20, 32'hB4);
        cyc(1'b1, 1'b0, 1'b0, 32'h20, 32'hB4);
        drain_all();

        // Continuous stores, pointers wrap
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 32'(4 * i), $urandom);
        drain_all();

        // Reset while three stores are pending
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 32'h40 + 32'(4 * i), 32'hDEAD_0000 + 32'(i));
        cyc(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Random mix; upper address bits vary so only the word field must match
        for (int i = 0; i < 300; i++) begin
            int unsigned r;
            logic [31:0] a;
            r = $urandom_range(0, 5);
            a = ($urandom & 32'hFFFF_FF80) | (32'($urandom_range(0, 7)) << 2);
            case (r)
                0:       cyc(1'b0, 1'b0, 1'b0, a, $urandom);
                1, 2:    cyc(1'b1, 1'b0, 1'b0, a, $urandom);
                3:       cyc(1'b0, 1'b1, 1'b0, a, $urandom);
                4:       cyc(1'b1, 1'b1, 1'b0, a, $urandom);
                default: cyc(($urandom_range(0, 1) == 1), 1'b1, 1'b0, a, $urandom);
            endcase
        end
        drain_all();

        for (int i = 0; i < c_WORDS; i++) check($sformatf("ram[%0d]", i), ram[i], exp_ram[i]);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
`default_nettype wire
